scfifo_stream_reader: RTL and testbench

- Drains a show-ahead single-clock FIFO (empty / rdreq / q interface) and presents the words as a valid/ready streaming source.
- Uses a registered 2-entry skid buffer, so the FIFO's rdreq never depends combinationally on downstream ready.
- Sits between the per-channel parameter_scfifo instances and downstream packet/MAC-side logic in the 8-channel datapath.
- Provides enable gating, synchronous flush and a transferred-word counter for status.

---
 rtl/scfifo_stream_reader_if.sv | 34 +++
 rtl/scfifo_stream_reader.sv | 99 +++++++++
 tb/tb_scfifo_stream_reader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scfifo_stream_reader_if.sv
// Bundle of the upstream show-ahead FIFO read port and the downstream stream port
// of scfifo_stream_reader. The reader uses the master view; the environment uses the slave view.

interface scfifo_stream_reader_if #(
    parameter int DATA_WIDTH = 64
);
    // Handshake: fifo_q is valid whenever fifo_empty=0 and is consumed on an edge with
    // fifo_rdreq=1. A stream word moves on an edge with out_valid=1 and out_ready=1; while
    // out_valid=1 and out_ready=0, out_valid and out_data hold unchanged.
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_q;
    logic                  fifo_rdreq;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        input  fifo_empty,
        input  fifo_q,
        input  out_ready,
        output fifo_rdreq,
        output out_valid,
        output out_data
    );

    modport slave (
        output fifo_empty,
        output fifo_q,
        output out_ready,
        input  fifo_rdreq,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/scfifo_stream_reader.sv
// Drains a show-ahead FIFO into a valid/ready stream through a registered 2-entry skid buffer,
// with enable gating, synchronous flush and a count of words accepted downstream.

module scfifo_stream_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clock,
    input  logic                         aclr_n,
    scfifo_stream_reader_if.master       strm,
    input  logic                         enable,
    input  logic                         flush,
    output logic [CNT_WIDTH-1:0]         word_count,
    output logic                         busy,
    output logic [1:0]                   occ_dbg
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e                  occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic                  pop;
    logic                  acc;

    // pop depends only on registered occupancy, never on out_ready; held low while in reset.
    always_comb begin
        pop = aclr_n && !strm.fifo_empty && enable && !flush &&
              ((occ_q == OCC_EMPTY) || (occ_q == OCC_ONE));
        acc = out_valid_q && strm.out_ready;
    end

    always_comb begin
        occ_d        = occ_q;
        head_d       = head_q;
        skid_d       = skid_q;
        word_count_d = word_count_q + CNT_WIDTH'(acc);
        case (occ_q)
            OCC_EMPTY: begin
                if (pop) begin
                    occ_d  = OCC_ONE;
                    head_d = strm.fifo_q;
                end
            end
            OCC_ONE: begin
                if (acc && pop) begin
                    head_d = strm.fifo_q;
                end else if (acc) begin
                    occ_d = OCC_EMPTY;
                end else if (pop) begin
                    occ_d  = OCC_FULL;
                    skid_d = strm.fifo_q;
                end
            end
            OCC_FULL: begin
                if (acc) begin
                    occ_d  = OCC_ONE;
                    head_d = skid_q;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        // Flush discards whatever is buffered, including the skid word promoted by an accept.
        if (flush) begin
            occ_d = OCC_EMPTY;
        end
        out_valid_d = (occ_d != OCC_EMPTY);
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            occ_q        <= OCC_EMPTY;
            head_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            word_count_q <= '0;
        end else begin
            occ_q        <= occ_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            word_count_q <= word_count_d;
        end
    end

    assign strm.fifo_rdreq = pop;
    assign strm.out_valid  = out_valid_q;
    assign strm.out_data   = head_q;
    assign busy            = out_valid_q;
    assign word_count      = word_count_q;
    assign occ_dbg         = occ_q;

endmodule

// File: tb/tb_scfifo_stream_reader.sv
// Bench for scfifo_stream_reader: queue-based upstream FIFO, buffer/scoreboard model,
// directed scenarios followed by randomized traffic.

module tb_scfifo_stream_reader;

    localparam int DW = 64;
    localparam int CW = 4;

    logic          clock  = 1'b0;
    logic          aclr_n = 1'b1;
    logic          enable = 1'b0;
    logic          flush  = 1'b0;
    logic [CW-1:0] word_count;
    logic          busy;
    logic [1:0]    occ_dbg;

    scfifo_stream_reader_if #(.DATA_WIDTH(DW)) sif ();

    scfifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clock      (clock),
        .aclr_n     (aclr_n),
        .strm       (sif.master),
        .enable     (enable),
        .flush      (flush),
        .word_count (word_count),
        .busy       (busy),
        .occ_dbg    (occ_dbg)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- upstream FIFO ----------------
    logic [DW-1:0] fifo_mem [256];
    int            fifo_rd = 0;
    int            fifo_wr = 0;

    assign sif.fifo_empty = (fifo_rd == fifo_wr);
    assign sif.fifo_q     = fifo_mem[fifo_rd % 256];

    // ---------------- reference model + scoreboard ----------------
    int            n_checks     = 0;
    int            n_pass       = 0;
    int            rdreq_pulses = 0;
    int            m_occ        = 0;
    logic [CW-1:0] exp_cnt      = '0;
    logic [DW-1:0] exp_q [$];
    bit            m_acc;
    bit            m_pop;

    function automatic void check(input string name, input logic [DW-1:0] act,
                                  input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    // Buffer of up to two words in flight; every popped word is expected downstream in order
    // unless a flush discards it first.
    always @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            m_occ   = 0;
            exp_q.delete();
            exp_cnt = '0;
        end else begin
            m_acc = (m_occ != 0) && sif.out_ready;
            m_pop = (fifo_rd != fifo_wr) && enable && !flush && (m_occ < 2);
            if (m_acc) exp_cnt = exp_cnt + 1'b1;
            if (flush) begin
                exp_q.delete();
                m_occ = 0;
            end else begin
                m_occ = m_occ - int'(m_acc) + int'(m_pop);
                if (m_pop) begin
                    exp_q.push_back(fifo_mem[fifo_rd % 256]);
                    fifo_rd <= fifo_rd + 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (aclr_n) begin
            check("occ_legal", DW'(occ_dbg != 2'd3), DW'(1));
            check("out_valid", DW'(sif.out_valid), DW'(m_occ != 0));
            check("busy", DW'(busy), DW'(m_occ != 0));
            check("rdreq", DW'(sif.fifo_rdreq),
                  DW'((fifo_rd != fifo_wr) && enable && !flush && (m_occ < 2)));
            check("word_count", DW'(word_count), DW'(exp_cnt));
            if (sif.fifo_rdreq) rdreq_pulses++;
            if (sif.out_valid && sif.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_data: got %h with no word expected (t=%0t)",
                             sif.out_data, $time);
                end else begin
                    check("out_data", sif.out_data, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_mem[fifo_wr % 256] = w;
        fifo_wr++;
    endtask

    task automatic apply_reset();
        aclr_n = 1'b0;
        tick();
        tick();
        aclr_n = 1'b1;
    endtask

    task automatic drain(input string name);
        bit idle;
        idle = 1'b0;
        enable          = 1'b1;
        flush           = 1'b0;
        sif.out_ready   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (fifo_rd == fifo_wr && m_occ == 0) begin
                idle = 1'b1;
                break;
            end
            tick();
        end
        check(name, DW'(idle), DW'(1));
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] w0;

    initial begin
        sif.out_ready = 1'b0;
        #1 aclr_n = 1'b0;

        // Basic burst; FIFO already non-empty and enable high while in reset.
        push(64'hA1); push(64'hA2); push(64'hA3);
        enable        = 1'b1;
        sif.out_ready = 1'b1;
        tick(); tick();
        @(negedge clock);
        check("rst_out_valid", DW'(sif.out_valid), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_word_count", DW'(word_count), DW'(0));
        check("rst_rdreq", DW'(sif.fifo_rdreq), DW'(0));
        check("rst_out_data", sif.out_data, DW'(0));
        @(posedge clock); #1;
        aclr_n = 1'b1;
        @(negedge clock);
        check("basic_first_rdreq", DW'(sif.fifo_rdreq), DW'(1));
        check("basic_not_yet_valid", DW'(sif.out_valid), DW'(0));
        @(negedge clock);
        check("basic_w0", sif.out_data, 64'hA1);
        @(negedge clock);
        check("basic_w1", sif.out_data, 64'hA2);
        @(negedge clock);
        check("basic_w2", sif.out_data, 64'hA3);
        @(negedge clock);
        check("basic_count", DW'(word_count), DW'(3));
        check("basic_busy", DW'(busy), DW'(0));
        tick();

        // Backpressure: at most two pops while stalled, head word held.
        apply_reset();
        sif.out_ready = 1'b0;
        w0 = {$urandom, $urandom};
        push(w0);
        for (int i = 1; i < 5; i++) push({$urandom, $urandom});
        rdreq_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i >= 2) check("bp_hold_data", sif.out_data, w0);
            @(posedge clock); #1;
        end
        check("bp_rdreq_pulses", DW'(rdreq_pulses), DW'(2));
        drain("bp_drain");
        check("bp_count", DW'(word_count), DW'(5));

        // Enable gating with one word buffered.
        apply_reset();
        enable        = 1'b0;
        sif.out_ready = 1'b0;
        push(64'hE0); push(64'hE1); push(64'hE2);
        tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        @(negedge clock);
        check("en_no_rdreq", DW'(sif.fifo_rdreq), DW'(0));
        check("en_held_word", sif.out_data, 64'hE0);
        tick();
        sif.out_ready = 1'b1;
        @(negedge clock);
        check("en_drain_valid", DW'(sif.out_valid), DW'(1));
        tick();
        @(negedge clock);
        check("en_empty", DW'(sif.out_valid), DW'(0));
        tick();
        enable = 1'b1;
        @(negedge clock);
        check("en_resume_rdreq", DW'(sif.fifo_rdreq), DW'(1));
        tick();
        drain("en_drain");
        check("en_count", DW'(word_count), DW'(3));

        // Flush with two words buffered and an accept in the flush cycle.
        apply_reset();
        sif.out_ready = 1'b0;
        enable        = 1'b1;
        push(64'hB0); push(64'hB1); push(64'hB2);
        tick(); tick(); tick();
        @(negedge clock);
        check("fl_full_rdreq", DW'(sif.fifo_rdreq), DW'(0));
        check("fl_head", sif.out_data, 64'hB0);
        tick();
        flush         = 1'b1;
        sif.out_ready = 1'b1;
        @(negedge clock);
        check("fl_rdreq_blocked", DW'(sif.fifo_rdreq), DW'(0));
        tick();
        flush = 1'b0;
        @(negedge clock);
        check("fl_valid_dropped", DW'(sif.out_valid), DW'(0));
        check("fl_count", DW'(word_count), DW'(1));
        tick();
        @(negedge clock);
        check("fl_next_word", sif.out_data, 64'hB2);
        tick();
        drain("fl_drain");
        check("fl_final_count", DW'(word_count), DW'(2));

        // Counter wrap at CW bits.
        apply_reset();
        for (int i = 0; i < 17; i++) push(DW'(i + 16'h100));
        drain("wrap_drain");
        check("wrap_count", DW'(word_count), DW'(1));

        // Asynchronous reset with the buffer full.
        sif.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push({$urandom, $urandom});
        tick(); tick(); tick();
        #2 aclr_n = 1'b0;
        #1;
        check("arst_out_valid", DW'(sif.out_valid), DW'(0));
        check("arst_busy", DW'(busy), DW'(0));
        check("arst_rdreq", DW'(sif.fifo_rdreq), DW'(0));
        check("arst_count", DW'(word_count), DW'(0));
        tick();
        aclr_n = 1'b1;
        @(negedge clock);
        check("arst_restart_rdreq", DW'(sif.fifo_rdreq), DW'(1));
        tick();
        drain("arst_drain");
        check("arst_final_count", DW'(word_count), DW'(2));

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            sif.out_ready = ($urandom_range(0, 3) != 0);
            enable        = ($urandom_range(0, 7) != 0);
            flush         = ($urandom_range(0, 24) == 0);
            if ((fifo_wr - fifo_rd) < 200 && $urandom_range(0, 1) == 1)
                push({$urandom, $urandom});
            tick();
        end
        drain("rand_drain");
        check("rand_leftover", DW'(exp_q.size()), DW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
